// File: rtl/fb_pkg.sv
// Shared constants and types for the 320x240x8 framebuffer arbiter.
// Geometry, bus widths and the clear sequencer state encoding.
package fb_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 8;

    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear sequencer: walks every framebuffer address once per clr_start,
// advancing only on cycles the arbiter grants it the RAM.
module fb_clear_seq
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
);

    localparam logic [0:0]        ST_IDLE   = CLR_IDLE;
    localparam logic [0:0]        ST_RUN    = CLR_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    // start is only looked at in idle, so a pulse during the final grant is lost
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (grant) begin
                    if (cnt_reg == LAST_ADDR) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign req  = busy;
    assign addr = cnt_reg;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads, waterfall writes and the
// clear sequencer share one registered RAM command port.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int                DATA_W     = FB_DATA_W,
    parameter int                ADDR_W     = FB_ADDR_W,
    parameter int                DEPTH      = FB_DEPTH,
    parameter int                STARVE_MAX = 15,
    parameter logic [DATA_W-1:0] CLR_VALUE  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int              SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam int              AW1        = ADDR_W + 1;
    localparam logic [AW1-1:0]  DEPTH_L    = AW1'(DEPTH);
    localparam int              RD_LAT     = 2;

    logic              grant_rd;
    logic              grant_wr;
    logic              grant_clr;
    logic              force_wr;
    logic              wr_in_range;

    logic              clr_req;
    logic [ADDR_W-1:0] clr_addr;

    logic [SW-1:0]     starve_reg;
    logic [SW-1:0]     starve_next;

    logic [ADDR_W-1:0] ram_addr_reg;
    logic [ADDR_W-1:0] ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic [DATA_W-1:0] ram_wdata_next;
    logic              ram_we_reg;
    logic              ram_we_next;

    logic [RD_LAT-1:0] rd_pipe_reg;
    logic [RD_LAT-1:0] rd_pipe_next;

    fb_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk   (clk),
        .reset (reset),
        .start (clr_start),
        .grant (grant_clr),
        .req   (clr_req),
        .addr  (clr_addr),
        .busy  (clr_busy)
    );

    // Writer jumps ahead of the reader once it has waited STARVE_MAX cycles
    assign force_wr    = (STARVE_MAX != 0) && (starve_reg == STARVE_LIM);
    assign grant_rd    = rd_valid && !(force_wr && wr_valid);
    assign grant_wr    = wr_valid && (force_wr || !rd_valid);
    assign grant_clr   = clr_req && !rd_valid && !wr_valid;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);

    assign rd_ready = grant_rd;
    assign wr_ready = grant_wr;

    always_comb begin
        starve_next = starve_reg;
        if (!wr_valid || grant_wr) begin
            starve_next = '0;
        end else if (starve_reg != STARVE_LIM) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // Out-of-range writes are still handshaken, just never reach the RAM
    always_comb begin
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        ram_we_next    = 1'b0;
        if (grant_rd) begin
            ram_addr_next = rd_addr;
        end else if (grant_wr) begin
            ram_addr_next  = wr_addr;
            ram_wdata_next = wr_data;
            ram_we_next    = wr_in_range;
        end else if (grant_clr) begin
            ram_addr_next  = clr_addr;
            ram_wdata_next = CLR_VALUE;
            ram_we_next    = 1'b1;
        end
    end

    // Command register stage plus the RAM's own read register give two cycles
    assign rd_pipe_next = {rd_pipe_reg[RD_LAT-2:0], grant_rd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_reg    <= '0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_we_reg    <= 1'b0;
            rd_pipe_reg   <= '0;
        end else begin
            starve_reg    <= starve_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            ram_we_reg    <= ram_we_next;
            rd_pipe_reg   <= rd_pipe_next;
        end
    end

    assign ram_addr      = ram_addr_reg;
    assign ram_wdata     = ram_wdata_reg;
    assign ram_we        = ram_we_reg;
    assign rd_data_valid = rd_pipe_reg[RD_LAT-1];
    assign rd_data       = rd_data_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomised scoreboard bench for fb_arbiter against an abstract framebuffer
// model; a small frame keeps full clears short.
module tb_fb_arbiter;

    localparam int DEPTH      = 1200;
    localparam int STARVE_MAX = 3;
    localparam int MEM_N      = 131072;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_valid = 1'b0;
    logic [16:0] rd_addr = '0;
    logic        rd_ready;
    logic        rd_data_valid;
    logic [7:0]  rd_data;
    logic        wr_valid = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = '0;

    logic [7:0]  ram     [0:MEM_N-1];
    logic [7:0]  ref_mem [0:MEM_N-1];
    rd_exp_t     q[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    int          m_blocked = 0;
    bit          m_clr_active = 1'b0;
    int          m_clr_pos = 0;
    int          prev_kind = 0;
    logic [16:0] exp_addr = '0;
    bit          exp_we = 1'b0;
    logic [7:0]  exp_wdata = '0;
    bit          last_wr_ready;
    bit          last_busy;

    fb_arbiter #(
        .DATA_W     (8),
        .ADDR_W     (17),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .CLR_VALUE  (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_ready      (rd_ready),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 37 + (a >> 7) + 5);
    endfunction

    // Single-port RAM with one-cycle registered read
    initial begin
        for (int i = 0; i < MEM_N; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            ram_rdata <= ram[ram_addr];
            if (ram_we) ram[ram_addr] = ram_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every returned read must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_missing: read due at cycle %0d not seen by cycle %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (rd_data_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_unexpected at cycle %0d: data %0h with no read outstanding", cyc, rd_data);
                end else begin
                    chk("rd_latency", 32'(cyc), 32'(q[0].cyc));
                    chk("rd_data", 32'(rd_data), 32'(q[0].data));
                    void'(q.pop_front());
                end
            end
        end
    end

    // One arbitration cycle: check DUT against model, then advance the model
    task automatic step();
        bit force_w, g_rd, g_wr, g_clr, was_active;
        @(negedge clk);
        force_w = (STARVE_MAX != 0) && (m_blocked == STARVE_MAX);
        g_rd    = rd_valid && !(force_w && wr_valid);
        g_wr    = wr_valid && (force_w || !rd_valid);
        g_clr   = m_clr_active && !rd_valid && !wr_valid;
        chk("rd_ready", 32'(rd_ready), 32'(g_rd));
        chk("wr_ready", 32'(wr_ready), 32'(g_wr));
        chk("clr_busy", 32'(clr_busy), 32'(m_clr_active));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (prev_kind != 0) chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
        last_wr_ready = wr_ready;
        last_busy     = clr_busy;

        prev_kind  = 0;
        exp_we     = 1'b0;
        was_active = m_clr_active;
        if (g_rd) begin
            q.push_back('{data: ref_mem[rd_addr], cyc: cyc + 2});
            prev_kind = 1;
            exp_addr  = rd_addr;
        end else if (g_wr) begin
            prev_kind = 2;
            exp_addr  = wr_addr;
            exp_wdata = wr_data;
            exp_we    = (int'(wr_addr) < DEPTH);
            if (exp_we) ref_mem[wr_addr] = wr_data;
        end else if (g_clr) begin
            prev_kind = 3;
            exp_addr  = 17'(m_clr_pos);
            exp_wdata = 8'h00;
            exp_we    = 1'b1;
            ref_mem[m_clr_pos] = 8'h00;
            m_clr_pos++;
            if (m_clr_pos == DEPTH) m_clr_active = 1'b0;
        end
        if (!was_active && clr_start) begin
            m_clr_active = 1'b1;
            m_clr_pos    = 0;
        end
        if (!wr_valid || g_wr) m_blocked = 0;
        else if (m_blocked < STARVE_MAX) m_blocked++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rv, input int ra, input bit wv, input int wa,
                         input logic [7:0] wd, input bit cs);
        rd_valid  = rv;
        rd_addr   = 17'(ra);
        wr_valid  = wv;
        wr_addr   = 17'(wa);
        wr_data   = wd;
        clr_start = cs;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_rd_data_valid"}, 32'(rd_data_valid), 32'd0);
        chk({tag, "_clr_busy"}, 32'(clr_busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_val(i);

        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Back-to-back reads of known data
        drive(0, 0, 1, 0, 8'h11, 0);
        drive(0, 0, 1, 1, 8'h22, 0);
        drive(0, 0, 1, 2, 8'h33, 0);
        drive(0, 0, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 0, 8'h00, 0);
        drive(1, 1, 0, 0, 8'h00, 0);
        drive(1, 2, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Starvation forcing: write wins on the 4th and 8th contended cycles
        for (int i = 0; i < 8; i++) begin
            drive(1, $urandom_range(0, DEPTH - 1), 1, 100 + i, 8'(8'h80 + i), 0);
            chk("starve_wr_grant", 32'(last_wr_ready), 32'((i == 3) || (i == 7)));
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Address boundary: DEPTH is dropped, DEPTH-1 is stored
        drive(0, 0, 1, DEPTH, 8'hAA, 0);
        drive(0, 0, 1, DEPTH - 1, 8'h5A, 0);
        drive(0, 0, 0, 0, 8'h00, 0);
        drive(1, DEPTH - 1, 0, 0, 8'h00, 0);
        drive(1, DEPTH, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Random mixed traffic with occasional clears
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 40, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 99) < 45, $urandom_range(0, DEPTH + 3),
                  8'($urandom_range(0, 255)), $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 3 * DEPTH && m_clr_active; i++) drive(0, 0, 0, 0, 8'h00, 0);
        chk("random_clear_done", 32'(m_clr_active), 32'd0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Idle clear: busy for exactly DEPTH cycles, second start ignored
        drive(0, 0, 0, 0, 8'h00, 1);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            drive(0, 0, 0, 0, 8'h00, i == 500);
            if (last_busy) busy_cnt++;
        end
        chk("clear_idle_cycles", 32'(busy_cnt), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) drive(1, a, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Clear pre-empted by 100 cycles of reads
        drive(0, 0, 0, 0, 8'h00, 1);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 120; i++) begin
            drive((i >= 300) && (i < 400), $urandom_range(0, DEPTH - 1), 0, 0, 8'h00, 0);
            if (last_busy) busy_cnt++;
        end
        chk("clear_stall_cycles", 32'(busy_cnt), 32'(DEPTH + 100));
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Asynchronous reset mid-clear and mid-read
        drive(0, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 500; i++) drive(0, 0, 0, 0, 8'h00, 0);
        chk("clear_pos_500", 32'(m_clr_pos), 32'd500);
        for (int i = 0; i < 3; i++) drive(1, i + 700, 0, 0, 8'h00, 0);
        rd_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        m_clr_active = 1'b0;
        m_clr_pos    = 0;
        m_blocked    = 0;
        prev_kind    = 0;
        exp_we       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 8'h00, 0);

        // Fresh clear after reset, spot-check the result
        drive(0, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < DEPTH + 5; i++) drive(0, 0, 0, 0, 8'h00, 0);
        for (int a = 0; a < 8; a++) drive(1, a * 150 + 3, 0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 8'h00, 0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port 320x240x8 framebuffer RAM (17-bit address, 1-cycle registered read) between three requesters:
  - display scanout reads
  - waterfall pixel writes
  - an internal clear sequencer that zero-fills the buffer
- Sits between the RAM and the video/waterfall logic.
- Issues at most one RAM command per cycle, registered, and returns read data with a fixed latency.

Parameters:
- DATA_W, 8, pixel width
- ADDR_W, 17, RAM address width
- DEPTH, 76800, number of valid pixel addresses (320*240)
- STARVE_MAX, 15, consecutive blocked writer cycles before the writer is forced ahead of the reader; 0 disables forcing
- CLR_VALUE, 0, pixel value written by the clear sequencer

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_valid  in  1  display read request
- rd_addr  in  ADDR_W  read address
- rd_ready  out  1  read request accepted this cycle
- rd_data_valid  out  1  rd_data holds the result of a read
- rd_data  out  DATA_W  read result
- wr_valid  in  1  pixel write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write request accepted this cycle
- clr_start  in  1  single-cycle pulse that starts a full clear
- clr_busy  out  1  clear in progress
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the command

Behaviour:
- One clock domain. reset is asynchronous and active-high. On reset, every register clears:
  - ram_addr=0, ram_wdata=0, ram_we=0
  - rd_data_valid=0, clr_busy=0
  - starve counter=0, clear counter=0, clear FSM in IDLE
- Arbitration is combinational within cycle T:
  - Default priority: read > write > clear.
  - When force_wr=1 (starve counter == STARVE_MAX, STARVE_MAX != 0), priority is write > read > clear.
  - rd_ready = grant_rd; wr_ready = grant_wr. Each ready is independent of its own valid's value only through priority (no combinational loop).
  - A transfer occurs when valid && ready.
- Command register, loaded at the end of cycle T:
  - Read grant: ram_addr=rd_addr, ram_we=0.
  - Write grant: ram_addr=wr_addr, ram_wdata=wr_data, ram_we = (wr_addr < DEPTH). An out-of-range write is accepted and dropped.
  - Clear grant: ram_addr=clr_cnt, ram_wdata=CLR_VALUE, ram_we=1.
  - No grant: ram_we=0; ram_addr holds its previous value.
- Read latency:
  - Request granted in cycle T → rd_data_valid=1 in cycle T+2.
  - rd_data = ram_rdata combinationally, qualified by a 2-stage valid pipe.
  - Back-to-back reads sustain 1 per cycle, in order.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle wr_valid && !wr_ready.
  - Clears on a write grant or when wr_valid=0.
- Clear FSM:
  - IDLE: clr_busy=0. clr_start=1 → CLEAR, clr_cnt=0.
  - CLEAR: clr_busy=1. The clear requests every cycle. On each clear grant, clr_cnt increments. A grant with clr_cnt == DEPTH-1 → IDLE next cycle.
  - clr_start is ignored in CLEAR and on the final-grant cycle.
  - Reader and writer pre-empt the clear, so a clear takes ≥ DEPTH cycles. A write landing before the clear reaches that address is overwritten with CLR_VALUE.
- Reset mid-clear aborts the clear. Cleared and uncleared regions are left as-is. In-flight read valids are dropped.
- Simultaneous rd_valid, wr_valid and an active clear with force_wr=0: only the read proceeds; writer and clear stall.

Decomposition:
- Shared package fb_pkg holds:
  - FB_W=320, FB_H=240, FB_DEPTH=76800
  - FB_ADDR_W=17, FB_DATA_W=8
  - the clear FSM state enum {CLR_IDLE, CLR_RUN}
- One natural sub-module, fb_clear_seq: clear FSM plus address counter, exposing req/grant/addr/busy.

Test Plan:
- Reads back-to-back to addresses 0,1,2 after the RAM model holds 0x11,0x22,0x33 → rd_data_valid high in cycles T+2..T+4 with 0x11,0x22,0x33 in order.
- rd_valid and wr_valid held high together with STARVE_MAX=3 → reads granted for 3 cycles, the 4th cycle grants the write (ram_we=1), then reads resume and the counter returns to 0.
- Write addr=76800, data=0xAA → wr_ready=1, ram_we stays 0, no RAM change. Write addr=76799, data=0x5A → the RAM model reads back 0x5A.
- clr_start with no other traffic → clr_busy high for exactly 76800 cycles, and every address reads 0x00 afterwards. A second clr_start mid-clear is ignored.
- Clear running with continuous rd_valid for 100 cycles → the clear stalls at a fixed clr_cnt for 100 cycles, then resumes and clr_busy is extended by 100 cycles.
- reset asserted mid-clear and mid-read at clr_cnt=500 → all outputs zero immediately (asynchronously), no rd_data_valid after deassert, and clr_busy stays 0 until a new clr_start.
